// File: rtl/vga_grayscale_capture.sv
// VGA/DVI capture front end: recovers column/row from DE/VSYNC and converts {R,G,B} to replicated luma.
// Latency: 2 cycles from accepted pixel strobe to O_PIXEL_WRITE_ENABLE; O_FRAME_DONE 1 cycle after last write.
// Backpressure: none; one pixel per cycle sustained. Optional macro VGA_GRAYSCALE_BYPASS_EN adds I_BYPASS.
module vga_grayscale_capture #(
  parameter int P_COLUMNS      = 640,
  parameter int P_ROWS         = 480,
  parameter int P_CHANNEL_BITS = 8,
  parameter int P_WEIGHT_BITS  = 8,
  parameter int P_WEIGHT_R     = 77,
  parameter int P_WEIGHT_G     = 150,
  parameter int P_WEIGHT_B     = 29,
  parameter int P_VSYNC_ACTIVE = 1,
  localparam int P_PIXEL_DEPTH = 3 * P_CHANNEL_BITS,
  localparam int CW            = $clog2(P_COLUMNS),
  localparam int RW            = $clog2(P_ROWS)
) (
  input  logic                     I_CLK,
  input  logic                     I_RESET,
  input  logic                     I_ENABLE,
  input  logic                     I_PIX_VALID,
  input  logic [P_PIXEL_DEPTH-1:0] I_PIX_DATA,
`ifdef VGA_GRAYSCALE_BYPASS_EN
  input  logic                     I_BYPASS,
`endif
  input  logic                     I_VSYNC,
  input  logic                     I_DE,
  output logic [CW-1:0]            O_PIXEL_COL,
  output logic [RW-1:0]            O_PIXEL_ROW,
  output logic [P_PIXEL_DEPTH-1:0] O_PIXEL,
  output logic                     O_PIXEL_WRITE_ENABLE,
  output logic                     O_FRAME_DONE,
  output logic                     O_FRAME_ERR
);

  localparam int CB   = P_CHANNEL_BITS;
  localparam int PW   = P_CHANNEL_BITS + P_WEIGHT_BITS;
  localparam int SW   = PW + 2;
  localparam int CNTW = $clog2(P_COLUMNS + 1);

  localparam logic [CNTW-1:0] COL_FULL = CNTW'(P_COLUMNS);
  localparam logic [RW-1:0]   ROW_LAST = RW'(P_ROWS - 1);
  localparam logic [SW-1:0]   ROUND    = SW'(1 << (P_WEIGHT_BITS - 1));
  localparam logic [SW-1:0]   GRAY_MAX = SW'((1 << P_CHANNEL_BITS) - 1);
  localparam logic            VS_ACT   = (P_VSYNC_ACTIVE != 0);

  localparam logic [1:0] S_SYNC_WAIT = 2'd0;
  localparam logic [1:0] S_LINE_WAIT = 2'd1;
  localparam logic [1:0] S_ACTIVE    = 2'd2;

  logic [1:0]      state, state_nxt;
  logic [CNTW-1:0] col_cnt, col_nxt, acc_col;
  logic [RW-1:0]   row_cnt, row_nxt;
  logic            vs_act_q, de_q;
  logic            vsync_rise, de_fall;
  logic            accept, err_set, done_req;
  logic            bypass_in;

  logic            s1_vld, s1_done, s1_byp;
  logic [CW-1:0]   s1_col;
  logic [RW-1:0]   s1_row;
  logic [PW-1:0]   s1_pr, s1_pg, s1_pb;
  logic [P_PIXEL_DEPTH-1:0] s1_raw;
  logic [SW-1:0]   sum, shifted;
  logic [CB-1:0]   gray;

`ifdef VGA_GRAYSCALE_BYPASS_EN
  assign bypass_in = I_BYPASS;
`else
  assign bypass_in = 1'b0;
`endif

  // Edges are judged against the level seen at the previous pixel strobe, not the previous clock.
  assign vsync_rise = I_PIX_VALID && (I_VSYNC == VS_ACT) && !vs_act_q;
  assign de_fall    = I_PIX_VALID && !I_DE && de_q;

  // Remember DE/VSYNC at each strobe; VSYNC starts "active" so a level held through reset is not a new frame.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      vs_act_q <= 1'b1;
      de_q     <= 1'b0;
    end else if (I_PIX_VALID) begin
      vs_act_q <= (I_VSYNC == VS_ACT);
      de_q     <= I_DE;
    end
  end

  // Frame/line tracking: decide acceptance, coordinate updates and error/done events.
  always_comb begin
    state_nxt = state;
    col_nxt   = col_cnt;
    row_nxt   = row_cnt;
    acc_col   = '0;
    accept    = 1'b0;
    err_set   = 1'b0;
    done_req  = 1'b0;
    if (!I_ENABLE) begin
      state_nxt = S_SYNC_WAIT;
    end else begin
      case (state)
        S_SYNC_WAIT: begin
          if (vsync_rise) begin
            state_nxt = S_LINE_WAIT;
            row_nxt   = '0;
          end
        end
        S_LINE_WAIT: begin
          if (vsync_rise) begin
            err_set = 1'b1;
            row_nxt = '0;
          end else if (I_PIX_VALID && I_DE) begin
            state_nxt = S_ACTIVE;
            accept    = 1'b1;
            acc_col   = '0;
            col_nxt   = CNTW'(1);
          end
        end
        S_ACTIVE: begin
          if (vsync_rise) begin
            err_set   = 1'b1;
            row_nxt   = '0;
            state_nxt = S_LINE_WAIT;
          end else if (I_PIX_VALID && I_DE) begin
            if (col_cnt < COL_FULL) begin
              accept  = 1'b1;
              acc_col = col_cnt;
              col_nxt = col_cnt + CNTW'(1);
            end else begin
              // Overlong line: drop the pixel, counter stays saturated.
              err_set = 1'b1;
            end
          end else if (de_fall) begin
            if (col_cnt != COL_FULL) err_set = 1'b1;
            if (row_cnt == ROW_LAST) begin
              state_nxt = S_SYNC_WAIT;
              done_req  = 1'b1;
            end else begin
              row_nxt   = row_cnt + RW'(1);
              state_nxt = S_LINE_WAIT;
            end
          end
        end
        default: state_nxt = S_SYNC_WAIT;
      endcase
    end
  end

  // FSM state, counters and the sticky error flag.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state       <= S_SYNC_WAIT;
      col_cnt     <= '0;
      row_cnt     <= '0;
      O_FRAME_ERR <= 1'b0;
    end else begin
      state       <= state_nxt;
      col_cnt     <= col_nxt;
      row_cnt     <= row_nxt;
      O_FRAME_ERR <= O_FRAME_ERR | err_set;
    end
  end

  // Stage 1: weighted channel products plus coordinates; done request travels alongside.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      s1_vld  <= 1'b0;
      s1_done <= 1'b0;
      s1_byp  <= 1'b0;
      s1_col  <= '0;
      s1_row  <= '0;
      s1_pr   <= '0;
      s1_pg   <= '0;
      s1_pb   <= '0;
      s1_raw  <= '0;
    end else begin
      s1_vld  <= accept;
      s1_done <= done_req;
      if (accept) begin
        s1_byp <= bypass_in;
        s1_col <= CW'(acc_col);
        s1_row <= row_cnt;
        s1_raw <= I_PIX_DATA;
        s1_pr  <= PW'(I_PIX_DATA[3*CB-1:2*CB]) * PW'(P_WEIGHT_R);
        s1_pg  <= PW'(I_PIX_DATA[2*CB-1:CB])   * PW'(P_WEIGHT_G);
        s1_pb  <= PW'(I_PIX_DATA[CB-1:0])      * PW'(P_WEIGHT_B);
      end
    end
  end

  // Stage 2 arithmetic: round-to-nearest, drop fractional bits, clamp to channel range.
  always_comb begin
    sum     = SW'(s1_pr) + SW'(s1_pg) + SW'(s1_pb) + ROUND;
    shifted = sum >> P_WEIGHT_BITS;
    gray    = (shifted > GRAY_MAX) ? GRAY_MAX[CB-1:0] : shifted[CB-1:0];
  end

  // Output registers: data/coordinates only move on a write, so they hold between pixels.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      O_PIXEL_WRITE_ENABLE <= 1'b0;
      O_FRAME_DONE         <= 1'b0;
      O_PIXEL_COL          <= '0;
      O_PIXEL_ROW          <= '0;
      O_PIXEL              <= '0;
    end else begin
      O_PIXEL_WRITE_ENABLE <= s1_vld;
      O_FRAME_DONE         <= s1_done;
      if (s1_vld) begin
        O_PIXEL_COL <= s1_col;
        O_PIXEL_ROW <= s1_row;
        O_PIXEL     <= s1_byp ? s1_raw : {gray, gray, gray};
      end
    end
  end

endmodule

// File: tb/tb_vga_grayscale_capture.sv
// Directed bench for vga_grayscale_capture with a 4x3 frame.
// Writes and frame-done pulses are logged with cycle stamps; each test compares the log to hand-computed values.
module tb_vga_grayscale_capture;

  logic        I_CLK = 1'b0;
  logic        I_RESET;
  logic        I_ENABLE;
  logic        I_PIX_VALID;
  logic [23:0] I_PIX_DATA;
  logic        I_VSYNC;
  logic        I_DE;
`ifdef VGA_GRAYSCALE_BYPASS_EN
  logic        I_BYPASS;
`endif
  logic [1:0]  O_PIXEL_COL;
  logic [1:0]  O_PIXEL_ROW;
  logic [23:0] O_PIXEL;
  logic        O_PIXEL_WRITE_ENABLE;
  logic        O_FRAME_DONE;
  logic        O_FRAME_ERR;

  vga_grayscale_capture #(.P_COLUMNS(4), .P_ROWS(3)) dut (
    .I_CLK(I_CLK), .I_RESET(I_RESET), .I_ENABLE(I_ENABLE),
    .I_PIX_VALID(I_PIX_VALID), .I_PIX_DATA(I_PIX_DATA),
`ifdef VGA_GRAYSCALE_BYPASS_EN
    .I_BYPASS(I_BYPASS),
`endif
    .I_VSYNC(I_VSYNC), .I_DE(I_DE),
    .O_PIXEL_COL(O_PIXEL_COL), .O_PIXEL_ROW(O_PIXEL_ROW), .O_PIXEL(O_PIXEL),
    .O_PIXEL_WRITE_ENABLE(O_PIXEL_WRITE_ENABLE), .O_FRAME_DONE(O_FRAME_DONE),
    .O_FRAME_ERR(O_FRAME_ERR)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct { int col; int row; logic [23:0] pix; int cyc; } wr_t;
  wr_t wrq[$];
  int  doneq[$];
  int  stq[$];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;

  always @(posedge I_CLK) cyc <= cyc + 1;

  // Log writes and done pulses mid-cycle.
  always @(negedge I_CLK) begin
    wr_t w;
    if (O_PIXEL_WRITE_ENABLE) begin
      w.col = int'(O_PIXEL_COL);
      w.row = int'(O_PIXEL_ROW);
      w.pix = O_PIXEL;
      w.cyc = cyc;
      wrq.push_back(w);
    end
    if (O_FRAME_DONE) doneq.push_back(cyc);
  end

  task automatic clear_logs();
    wrq.delete(); doneq.delete(); stq.delete();
  endtask

  task automatic drive(input logic de, input logic vs, input logic [23:0] d);
    @(posedge I_CLK); #1;
    I_PIX_VALID = 1'b1; I_DE = de; I_VSYNC = vs; I_PIX_DATA = d;
    if (de) stq.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge I_CLK); #1;
      I_PIX_VALID = 1'b0;
    end
  endtask

  task automatic send_vsync();
    drive(1'b0, 1'b0, 24'h0);
    drive(1'b0, 1'b1, 24'h0);
    drive(1'b0, 1'b0, 24'h0);
  endtask

  task automatic send_line(input int n, input logic [23:0] d, input int gap);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, d);
      idle(gap);
    end
    drive(1'b0, 1'b0, 24'h0);
  endtask

  task automatic pulse_reset();
    @(posedge I_CLK); #1; I_RESET = 1'b1; I_PIX_VALID = 1'b0;
    @(posedge I_CLK); #1; I_RESET = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge I_CLK);
    #1;
    checks++; if (O_PIXEL_WRITE_ENABLE !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", O_PIXEL_WRITE_ENABLE); end
    checks++; if (O_PIXEL !== 24'h0) begin errors++; $display("FAIL reset_pixel: got %h expected 000000", O_PIXEL); end
    checks++; if ({O_PIXEL_COL, O_PIXEL_ROW} !== 4'h0) begin errors++; $display("FAIL reset_coord: got %h expected 0", {O_PIXEL_COL, O_PIXEL_ROW}); end
    checks++; if ({O_FRAME_DONE, O_FRAME_ERR} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {O_FRAME_DONE, O_FRAME_ERR}); end
    I_RESET = 1'b0;
    // Mid-line reset while strobes keep coming every cycle.
    send_vsync();
    repeat (3) drive(1'b1, 1'b0, 24'hFF0000);
    checks++; if (O_PIXEL_WRITE_ENABLE !== 1'b1 || O_PIXEL !== 24'h4D4D4D) begin errors++; $display("FAIL midline_pre: got we=%b pix=%h expected we=1 pix=4d4d4d", O_PIXEL_WRITE_ENABLE, O_PIXEL); end
    #2; I_RESET = 1'b1; #1;
    checks++; if ({O_PIXEL_WRITE_ENABLE, O_FRAME_DONE, O_FRAME_ERR} !== 3'b000 || O_PIXEL !== 24'h0 || {O_PIXEL_COL, O_PIXEL_ROW} !== 4'h0) begin
      errors++; $display("FAIL midline_reset: got we=%b pix=%h col=%0d row=%0d expected all 0", O_PIXEL_WRITE_ENABLE, O_PIXEL, O_PIXEL_COL, O_PIXEL_ROW);
    end
    repeat (3) drive(1'b1, 1'b0, 24'hFF0000);
    I_RESET = 1'b0;
    clear_logs();
    repeat (8) drive(1'b1, 1'b0, 24'hFF0000);
    drive(1'b0, 1'b0, 24'h0);
    repeat (8) drive(1'b1, 1'b0, 24'hFF0000);
    idle(4);
    checks++; if (wrq.size() !== 0) begin errors++; $display("FAIL after_reset_nowrite: got %0d writes expected 0", wrq.size()); end
  endtask

  task automatic test_full_frame();
    clear_logs();
    send_vsync();
    for (int r = 0; r < 3; r++) send_line(4, 24'hFF0000, 0);
    idle(6);
    checks++; if (wrq.size() !== 12) begin errors++; $display("FAIL frame_count: got %0d expected 12", wrq.size()); end
    for (int i = 0; i < wrq.size() && i < 12; i++) begin
      checks++;
      if (wrq[i].pix !== 24'h4D4D4D || wrq[i].col !== i % 4 || wrq[i].row !== i / 4 || wrq[i].cyc - stq[i] !== 2) begin
        errors++;
        $display("FAIL frame_px%0d: got pix=%h col=%0d row=%0d lat=%0d expected 4d4d4d col=%0d row=%0d lat=2",
                 i, wrq[i].pix, wrq[i].col, wrq[i].row, wrq[i].cyc - stq[i], i % 4, i / 4);
      end
    end
    checks++; if (doneq.size() !== 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", doneq.size()); end
    if (doneq.size() == 1 && wrq.size() == 12) begin
      checks++; if (doneq[0] !== wrq[11].cyc + 1) begin errors++; $display("FAIL frame_done_time: got cycle %0d expected %0d", doneq[0], wrq[11].cyc + 1); end
    end
    checks++; if (O_FRAME_ERR !== 1'b0) begin errors++; $display("FAIL frame_err: got %b expected 0", O_FRAME_ERR); end
  endtask

  task automatic test_extremes();
    logic [23:0] d;
    clear_logs();
    send_vsync();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        d = (c % 2 == 1) ? 24'h000000 : 24'hFFFFFF;
        drive(1'b1, 1'b0, d);
        idle(1);
      end
      drive(1'b0, 1'b0, 24'h0);
    end
    idle(6);
    checks++; if (wrq.size() !== 12) begin errors++; $display("FAIL extreme_count: got %0d expected 12", wrq.size()); end
    for (int i = 0; i < wrq.size() && i < 12; i++) begin
      d = (i % 2 == 1) ? 24'h000000 : 24'hFFFFFF;
      checks++;
      if (wrq[i].pix !== d || wrq[i].cyc - stq[i] !== 2) begin
        errors++; $display("FAIL extreme_px%0d: got pix=%h lat=%0d expected %h lat=2", i, wrq[i].pix, wrq[i].cyc - stq[i], d);
      end
    end
    checks++; if (doneq.size() !== 1) begin errors++; $display("FAIL extreme_done: got %0d expected 1", doneq.size()); end
    checks++; if (O_PIXEL_WRITE_ENABLE !== 1'b0 || O_PIXEL !== 24'h0 || O_PIXEL_COL !== 2'd3 || O_PIXEL_ROW !== 2'd2) begin
      errors++; $display("FAIL hold: got we=%b pix=%h col=%0d row=%0d expected 0 000000 3 2", O_PIXEL_WRITE_ENABLE, O_PIXEL, O_PIXEL_COL, O_PIXEL_ROW);
    end
  endtask

  task automatic test_long_line();
    clear_logs();
    send_vsync();
    send_line(5, 24'h102030, 0);
    send_line(4, 24'h102030, 0);
    send_line(4, 24'h102030, 0);
    idle(6);
    checks++; if (wrq.size() !== 12) begin errors++; $display("FAIL long_count: got %0d expected 12", wrq.size()); end
    if (wrq.size() >= 5) begin
      checks++; if (wrq[3].col !== 3 || wrq[3].row !== 0 || wrq[4].col !== 0 || wrq[4].row !== 1) begin
        errors++; $display("FAIL long_coords: got (%0d,%0d) (%0d,%0d) expected (3,0) (0,1)", wrq[3].col, wrq[3].row, wrq[4].col, wrq[4].row);
      end
      checks++; if (wrq[0].pix !== 24'h1D1D1D) begin errors++; $display("FAIL long_pix: got %h expected 1d1d1d", wrq[0].pix); end
    end
    checks++; if (O_FRAME_ERR !== 1'b1) begin errors++; $display("FAIL long_err: got %b expected 1", O_FRAME_ERR); end
    clear_logs();
    send_vsync();
    for (int r = 0; r < 3; r++) send_line(4, 24'h102030, 0);
    idle(6);
    checks++; if (wrq.size() !== 12 || doneq.size() !== 1) begin errors++; $display("FAIL clean_after_long: got %0d writes %0d done expected 12 1", wrq.size(), doneq.size()); end
    checks++; if (O_FRAME_ERR !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", O_FRAME_ERR); end
  endtask

  task automatic test_early_vsync();
    pulse_reset();
    checks++; if (O_FRAME_ERR !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", O_FRAME_ERR); end
    clear_logs();
    send_vsync();
    send_line(4, 24'hFF0000, 0);
    send_line(4, 24'hFF0000, 0);
    send_vsync();
    idle(2);
    checks++; if (O_FRAME_ERR !== 1'b1) begin errors++; $display("FAIL early_vsync_err: got %b expected 1", O_FRAME_ERR); end
    send_line(4, 24'hFF0000, 0);
    idle(6);
    checks++; if (wrq.size() !== 12) begin errors++; $display("FAIL early_count: got %0d expected 12", wrq.size()); end
    if (wrq.size() >= 12) begin
      checks++; if (wrq[8].row !== 0 || wrq[8].col !== 0 || wrq[11].row !== 0 || wrq[11].col !== 3) begin
        errors++; $display("FAIL resync_row: got (%0d,%0d)..(%0d,%0d) expected (0,0)..(3,0)", wrq[8].col, wrq[8].row, wrq[11].col, wrq[11].row);
      end
    end
    checks++; if (doneq.size() !== 0) begin errors++; $display("FAIL early_no_done: got %0d expected 0", doneq.size()); end
  endtask

  task automatic test_enable_drop();
    pulse_reset();
    clear_logs();
    send_vsync();
    drive(1'b1, 1'b0, 24'hFFFFFF);
    idle(3);
    drive(1'b1, 1'b0, 24'hFFFFFF);
    @(posedge I_CLK); #1; I_ENABLE = 1'b0; I_PIX_VALID = 1'b0;
    idle(2);
    drive(1'b1, 1'b0, 24'hFFFFFF);
    idle(3);
    drive(1'b1, 1'b0, 24'hFFFFFF);
    idle(3);
    drive(1'b0, 1'b0, 24'h0);
    idle(6);
    checks++; if (wrq.size() !== 2) begin errors++; $display("FAIL en_count: got %0d expected 2", wrq.size()); end
    for (int i = 0; i < wrq.size() && i < 2; i++) begin
      checks++;
      if (wrq[i].cyc - stq[i] !== 2 || wrq[i].col !== i || wrq[i].pix !== 24'hFFFFFF) begin
        errors++; $display("FAIL en_px%0d: got lat=%0d col=%0d pix=%h expected lat=2 col=%0d ffffff", i, wrq[i].cyc - stq[i], wrq[i].col, wrq[i].pix, i);
      end
    end
    I_ENABLE = 1'b1;
    clear_logs();
    send_line(4, 24'hFFFFFF, 0);
    idle(6);
    checks++; if (wrq.size() !== 0) begin errors++; $display("FAIL en_syncwait: got %0d writes expected 0", wrq.size()); end
  endtask

`ifdef VGA_GRAYSCALE_BYPASS_EN
  task automatic test_bypass();
    pulse_reset();
    clear_logs();
    send_vsync();
    I_BYPASS = 1'b1;
    drive(1'b1, 1'b0, 24'h123456);
    idle(1);
    I_BYPASS = 1'b0;
    drive(1'b1, 1'b0, 24'h123456);
    idle(5);
    checks++; if (wrq.size() !== 2) begin errors++; $display("FAIL byp_count: got %0d expected 2", wrq.size()); end
    if (wrq.size() >= 2) begin
      checks++; if (wrq[0].pix !== 24'h123456 || wrq[0].cyc - stq[0] !== 2 || wrq[0].col !== 0) begin
        errors++; $display("FAIL byp_pix: got %h lat=%0d col=%0d expected 123456 lat=2 col=0", wrq[0].pix, wrq[0].cyc - stq[0], wrq[0].col);
      end
      checks++; if (wrq[1].pix !== 24'h2E2E2E || wrq[1].col !== 1) begin
        errors++; $display("FAIL byp_off: got %h col=%0d expected 2e2e2e col=1", wrq[1].pix, wrq[1].col);
      end
    end
  endtask
`endif

  initial begin
    I_RESET = 1'b1; I_ENABLE = 1'b1; I_PIX_VALID = 1'b0;
    I_PIX_DATA = 24'h0; I_VSYNC = 1'b0; I_DE = 1'b0;
`ifdef VGA_GRAYSCALE_BYPASS_EN
    I_BYPASS = 1'b0;
`endif
    test_reset();
    test_full_frame();
    test_extremes();
    test_long_line();
    test_early_vsync();
    test_enable_drop();
`ifdef VGA_GRAYSCALE_BYPASS_EN
    test_bypass();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
